// File: rtl/speak_sid_mailbox.sv
// Speak&SID CPC-to-ATmega mailbox: speech FIFO, reply/status readback, SID strobes and SID clock.
// Define FIFO_FLUSH_EN to let a status write with data[7] set flush the FIFO and overflow flag.
module speak_sid_mailbox #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SID_DIV    = 4,
  parameter logic [15:0] SPEECH_ADR = 16'hFBEE,
  parameter logic [15:0] STATUS_ADR = 16'hFBDE,
  parameter logic [15:0] SID_BASE   = 16'hFAC0,
  parameter logic [15:0] SID_MASK   = 16'hFFE0
) (
  input  logic        iCPC_CLOCK,
  input  logic        iRESET_N,
  input  logic        iIORQ,
  input  logic        iRD,
  input  logic        iWR,
  input  logic [15:0] iADR,
  input  logic [7:0]  iCPC_DATA,
  output logic [7:0]  oCPC_DATA,
  output logic        oCPC_DATA_OE,
  input  logic [7:0]  iATMEGA_DATA,
  output logic [7:0]  oATMEGA_DATA,
  output logic        oFIFO_NONEMPTY,
  input  logic        iATMEGA_POP,
  input  logic        iATMEGA_STORE,
  input  logic        iATMEGA_READY,
  input  logic        iSID_ON,
  output logic        oSID_CS,
  output logic        oSID_RW,
  output logic        oSID_CLOCK
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned Half = SID_DIV / 2;
  localparam int unsigned DivW = (Half > 1) ? $clog2(Half) : 1;

  logic [1:0] iorq_sync_q, rd_sync_q, wr_sync_q, pop_sync_q, store_sync_q;
  logic [2:0] arm_q;
  logic       wr_act_q, rd_act_q, pop_q, store_q, rd_status_q;
  logic       wr_act, rd_act, wr_evt, rd_rise, rd_fall, pop_evt, store_evt;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      reply_q;
  logic            full, empty, flush, do_push, do_pop, ovf_set, ovf_clr, speech_wr;
  logic [4:0]      count_ext;
  logic [3:0]      level;
  logic [DivW-1:0] div_q;
  logic            sid_clk_q, speech_sel, status_sel, sid_sel;

  always_ff @(posedge iCPC_CLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      iorq_sync_q  <= 2'b11;
      rd_sync_q    <= 2'b11;
      wr_sync_q    <= 2'b11;
      pop_sync_q   <= 2'b00;
      store_sync_q <= 2'b00;
      arm_q        <= 3'b000;
      wr_act_q     <= 1'b0;
      rd_act_q     <= 1'b0;
      pop_q        <= 1'b0;
      store_q      <= 1'b0;
      rd_status_q  <= 1'b0;
    end else begin
      iorq_sync_q  <= {iorq_sync_q[0], iIORQ};
      rd_sync_q    <= {rd_sync_q[0], iRD};
      wr_sync_q    <= {wr_sync_q[0], iWR};
      pop_sync_q   <= {pop_sync_q[0], iATMEGA_POP};
      store_sync_q <= {store_sync_q[0], iATMEGA_STORE};
      arm_q        <= {arm_q[1:0], 1'b1};
      wr_act_q     <= wr_act;
      rd_act_q     <= rd_act;
      pop_q        <= pop_sync_q[1];
      store_q      <= store_sync_q[1];
      if (rd_rise) rd_status_q <= (iADR == STATUS_ADR);
    end
  end

  // Edges are masked until the synchronisers hold real pin levels, so a strobe still
  // active across reset release is not taken as a new transaction.
  assign wr_act    = ~iorq_sync_q[1] & ~wr_sync_q[1];
  assign rd_act    = ~iorq_sync_q[1] & ~rd_sync_q[1];
  assign wr_evt    = arm_q[2] & wr_act & ~wr_act_q;
  assign rd_rise   = arm_q[2] & rd_act & ~rd_act_q;
  assign rd_fall   = arm_q[2] & ~rd_act & rd_act_q;
  assign pop_evt   = arm_q[2] & pop_sync_q[1] & ~pop_q;
  assign store_evt = arm_q[2] & store_sync_q[1] & ~store_q;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign speech_wr = wr_evt & (iADR == SPEECH_ADR);
`ifdef FIFO_FLUSH_EN
  assign flush     = wr_evt & (iADR == STATUS_ADR) & iCPC_DATA[7];
`else
  assign flush     = 1'b0;
`endif
  assign do_pop    = pop_evt & ~empty & ~flush;
  assign do_push   = speech_wr & (~full | do_pop);
  assign ovf_set   = speech_wr & full & ~do_pop;
  assign ovf_clr   = rd_fall & rd_status_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (!do_push && do_pop) count_d = count_q - CntW'(1);
      if (ovf_set)      ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
    end
  end

  always_ff @(posedge iCPC_CLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      reply_q   <= 8'h00;
      div_q     <= '0;
      sid_clk_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (store_evt) reply_q <= iATMEGA_DATA;
      if (div_q == DivW'(Half - 1)) begin
        div_q     <= '0;
        sid_clk_q <= ~sid_clk_q;
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge iCPC_CLOCK) begin
    if (do_push) mem_q[wr_ptr_q] <= iCPC_DATA;
  end

  assign count_ext      = 5'(count_q);
  assign level          = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];
  assign oATMEGA_DATA   = mem_q[rd_ptr_q];
  assign oFIFO_NONEMPTY = ~empty;
  assign oSID_CLOCK     = sid_clk_q;

  assign speech_sel   = (iADR == SPEECH_ADR);
  assign status_sel   = (iADR == STATUS_ADR);
  assign oCPC_DATA_OE = ~iIORQ & ~iRD & (speech_sel | status_sel);
  assign oCPC_DATA    = speech_sel ? reply_q : {iATMEGA_READY, ovf_q, empty, full, level};

  assign sid_sel = iRESET_N & iSID_ON & ((iADR & SID_MASK) == SID_BASE) & ~iIORQ;
  assign oSID_CS = ~(sid_sel & (~iRD | ~iWR));
  assign oSID_RW = ~(sid_sel & ~iWR);

endmodule

// File: tb/tb_speak_sid_mailbox.sv
// Bench for speak_sid_mailbox: queue-based model checked every cycle plus directed literal checks.
module tb_speak_sid_mailbox;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned SID_DIV = 4;
  localparam logic [15:0] SPEECH  = 16'hFBEE;
  localparam logic [15:0] STATUS  = 16'hFBDE;
  localparam logic [15:0] SIDBASE = 16'hFAC0;
  localparam logic [15:0] SIDMASK = 16'hFFE0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iIORQ = 1'b1, iRD = 1'b1, iWR = 1'b1;
  logic [15:0] iADR = 16'h0000;
  logic [7:0]  iCPC_DATA = 8'h00, iATMEGA_DATA = 8'h00;
  logic        iATMEGA_POP = 1'b0, iATMEGA_STORE = 1'b0, iATMEGA_READY = 1'b1, iSID_ON = 1'b0;
  logic [7:0]  oCPC_DATA, oATMEGA_DATA;
  logic        oCPC_DATA_OE, oFIFO_NONEMPTY, oSID_CS, oSID_RW, oSID_CLOCK;

  always #5 clk = ~clk;

  speak_sid_mailbox #(.DEPTH(DEPTH), .SID_DIV(SID_DIV)) dut (
    .iCPC_CLOCK    (clk),
    .iRESET_N      (rst_n),
    .iIORQ         (iIORQ),
    .iRD           (iRD),
    .iWR           (iWR),
    .iADR          (iADR),
    .iCPC_DATA     (iCPC_DATA),
    .oCPC_DATA     (oCPC_DATA),
    .oCPC_DATA_OE  (oCPC_DATA_OE),
    .iATMEGA_DATA  (iATMEGA_DATA),
    .oATMEGA_DATA  (oATMEGA_DATA),
    .oFIFO_NONEMPTY(oFIFO_NONEMPTY),
    .iATMEGA_POP   (iATMEGA_POP),
    .iATMEGA_STORE (iATMEGA_STORE),
    .iATMEGA_READY (iATMEGA_READY),
    .iSID_ON       (iSID_ON),
    .oSID_CS       (oSID_CS),
    .oSID_RW       (oSID_RW),
    .oSID_CLOCK    (oSID_CLOCK)
  );

  int checks = 0;
  int errors = 0;

  // Model state: byte queue, sticky overflow, reply byte, clocks since reset release.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_reply = 8'h00;
  int         k = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] status_model();
    int n;
    logic [3:0] lvl;
    n = q.size();
    lvl = (n > 15) ? 4'hF : 4'(n);
    return {iATMEGA_READY, m_ovf, n == 0, n == int'(DEPTH), lvl};
  endfunction

  function automatic void model_write(input logic [15:0] adr, input logic [7:0] data,
                                      input bit with_pop);
`ifdef FIFO_FLUSH_EN
    if (adr == STATUS && data[7]) begin
      q.delete();
      m_ovf = 1'b0;
      return;
    end
`endif
    if (with_pop && q.size() != 0) void'(q.pop_front());
    if (adr == SPEECH) begin
      if (q.size() < int'(DEPTH)) q.push_back(data);
      else m_ovf = 1'b1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else k <= k + 1;
  end

  logic exp_oe, sid_hit;
  always @(negedge clk) begin
    #1;
    chk("nonempty", oFIFO_NONEMPTY, q.size() != 0);
    if (q.size() != 0) chk("head", oATMEGA_DATA, q[0]);
    chk("sid_clock", oSID_CLOCK, ((k / (SID_DIV / 2)) % 2) == 0);
    exp_oe = !iIORQ && !iRD && (iADR == SPEECH || iADR == STATUS);
    chk("cpc_oe", oCPC_DATA_OE, exp_oe);
    if (exp_oe) chk("cpc_data", oCPC_DATA, (iADR == SPEECH) ? m_reply : status_model());
    sid_hit = rst_n && iSID_ON && ((iADR & SIDMASK) == SIDBASE) && !iIORQ;
    chk("sid_cs", oSID_CS, !(sid_hit && (!iRD || !iWR)));
    chk("sid_rw", oSID_RW, !(sid_hit && !iWR));
  end

  task automatic cpc_write(input logic [15:0] adr, input logic [7:0] data, input bit with_pop);
    @(negedge clk);
    iADR = adr; iCPC_DATA = data; iIORQ = 1'b0; iWR = 1'b0;
    if (with_pop) iATMEGA_POP = 1'b1;
    repeat (3) @(posedge clk);
    #1 model_write(adr, data, with_pop);
    repeat (2) @(negedge clk);
    iIORQ = 1'b1; iWR = 1'b1; iATMEGA_POP = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cpc_read(input logic [15:0] adr, output logic [7:0] data,
                          output logic oe_during, output logic oe_after);
    @(negedge clk);
    iADR = adr; iIORQ = 1'b0; iRD = 1'b0;
    repeat (3) @(negedge clk);
    #1 data = oCPC_DATA; oe_during = oCPC_DATA_OE;
    @(negedge clk);
    iIORQ = 1'b1; iRD = 1'b1;
    #1 oe_after = oCPC_DATA_OE;
    repeat (3) @(posedge clk);
    #1 if (adr == STATUS) m_ovf = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic atm_pop();
    @(negedge clk);
    iATMEGA_POP = 1'b1;
    repeat (3) @(posedge clk);
    #1 if (q.size() != 0) void'(q.pop_front());
    @(negedge clk);
    iATMEGA_POP = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic atm_store(input logic [7:0] d);
    @(negedge clk);
    iATMEGA_DATA = d; iATMEGA_STORE = 1'b1;
    repeat (3) @(posedge clk);
    #1 m_reply = d;
    @(negedge clk);
    iATMEGA_STORE = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_status_expect(input string name, input logic [7:0] exp);
    logic [7:0] d;
    logic oe1, oe2;
    cpc_read(STATUS, d, oe1, oe2);
    chk(name, d, exp);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] d;
    logic oe1, oe2;
    logic [7:0] drain [8];
    int rises;
    logic prev;
    drain = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h77};

    // SID strobes stay inactive while reset is held even with a matching write.
    @(negedge clk);
    iSID_ON = 1'b1; iADR = 16'hFAC5; iIORQ = 1'b0; iWR = 1'b0;
    #1 chk("rst_sid_cs", oSID_CS, 1'b1);
    chk("rst_sid_rw", oSID_RW, 1'b1);
    @(negedge clk);
    iIORQ = 1'b1; iWR = 1'b1; iSID_ON = 1'b0; iADR = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_sid_clock", oSID_CLOCK, 1'b1);
    chk("rst_nonempty", oFIFO_NONEMPTY, 1'b0);
    repeat (5) @(negedge clk);
    read_status_expect("rst_status", 8'hA0);

    // Three bytes, status, show-ahead head and pop.
    cpc_write(SPEECH, 8'h11, 1'b0);
    cpc_write(SPEECH, 8'h22, 1'b0);
    cpc_write(SPEECH, 8'h33, 1'b0);
    read_status_expect("status_3", 8'h83);
    chk("head_11", oATMEGA_DATA, 8'h11);
    atm_pop();
    chk("head_22", oATMEGA_DATA, 8'h22);
    atm_pop();
    atm_pop();
    chk("empty_after_pops", oFIFO_NONEMPTY, 1'b0);

    // Nine writes into an 8-deep FIFO: overflow, then cleared by the status read.
    for (int i = 0; i < 9; i++) cpc_write(SPEECH, 8'(8'h40 + i), 1'b0);
    read_status_expect("status_ovf", 8'hD8);
    read_status_expect("status_ovf_clr", 8'h98);

    // Full FIFO with write and pop together: accepted, no overflow.
    cpc_write(SPEECH, 8'h77, 1'b1);
    read_status_expect("status_push_pop", 8'h98);
    for (int i = 0; i < 8; i++) begin
      chk("drain", oATMEGA_DATA, drain[i]);
      atm_pop();
    end
    chk("drained", oFIFO_NONEMPTY, 1'b0);

    // Reply register and output-enable window.
    atm_store(8'hA5);
    cpc_read(SPEECH, d, oe1, oe2);
    chk("reply", d, 8'hA5);
    chk("oe_during", oe1, 1'b1);
    chk("oe_after", oe2, 1'b0);
    iATMEGA_READY = 1'b0;
    read_status_expect("status_not_ready", 8'h20);
    iATMEGA_READY = 1'b1;

    // SID strobes.
    iSID_ON = 1'b1;
    @(negedge clk);
    iADR = 16'hFAC5; iIORQ = 1'b0; iWR = 1'b0;
    #1 chk("sid_wr_cs", oSID_CS, 1'b0);
    chk("sid_wr_rw", oSID_RW, 1'b0);
    repeat (4) @(negedge clk);
    iIORQ = 1'b1; iWR = 1'b1;
    #1 chk("sid_idle_cs", oSID_CS, 1'b1);
    @(negedge clk);
    iIORQ = 1'b0; iRD = 1'b0;
    #1 chk("sid_rd_cs", oSID_CS, 1'b0);
    chk("sid_rd_rw", oSID_RW, 1'b1);
    repeat (4) @(negedge clk);
    iIORQ = 1'b1; iRD = 1'b1;
    iSID_ON = 1'b0;
    @(negedge clk);
    iIORQ = 1'b0; iWR = 1'b0;
    #1 chk("sid_off_cs", oSID_CS, 1'b1);
    chk("sid_off_rw", oSID_RW, 1'b1);
    repeat (4) @(negedge clk);
    iIORQ = 1'b1; iWR = 1'b1;
    repeat (4) @(negedge clk);

    // SID clock: 17 samples one clock apart span exactly four periods.
    rises = 0;
    #1 prev = oSID_CLOCK;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1 if (!prev && oSID_CLOCK) rises++;
      prev = oSID_CLOCK;
    end
    chk("sid_clock_rises", 8'(rises), 8'd4);

    // Status write: flush when enabled, no effect otherwise.
    for (int i = 1; i <= 5; i++) cpc_write(SPEECH, 8'(i), 1'b0);
    cpc_write(STATUS, 8'h80, 1'b0);
`ifdef FIFO_FLUSH_EN
    read_status_expect("status_flush", 8'hA0);
    chk("flush_nonempty", oFIFO_NONEMPTY, 1'b0);
`else
    read_status_expect("status_noflush", 8'h85);
    chk("noflush_head", oATMEGA_DATA, 8'h01);
    for (int i = 0; i < 5; i++) atm_pop();
`endif

    // Reset in the middle of a speech write: the byte must never arrive.
    @(negedge clk);
    iADR = SPEECH; iCPC_DATA = 8'h99; iIORQ = 1'b0; iWR = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete(); m_ovf = 1'b0; m_reply = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    iIORQ = 1'b1; iWR = 1'b1;
    repeat (5) @(negedge clk);
    #1 chk("midwr_nonempty", oFIFO_NONEMPTY, 1'b0);
    read_status_expect("midwr_status", 8'hA0);
    cpc_read(SPEECH, d, oe1, oe2);
    chk("midwr_reply", d, 8'h00);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speak_sid_mailbox.md
Name: speak_sid_mailbox

Overview:
Synchronous CPC-to-ATmega mailbox for the Speak&SID expansion, clocked from the CPC 4 MHz clock. It decodes CPC I/O cycles and queues speech command bytes in a DEPTH-deep FIFO that the ATmega drains. It returns an ATmega reply byte and a status byte to the CPC, generates SID chip-select/RW, and divides the CPC clock to produce the SID clock.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of 2, 2..16
SID_DIV, 4, oSID_CLOCK period in iCPC_CLOCK cycles; even, >=2
SPEECH_ADR, 16'hFBEE, full-decode address for speech write (push) and read (reply)
STATUS_ADR, 16'hFBDE, full-decode address for status read
SID_BASE, 16'hFAC0, SID window base
SID_MASK, 16'hFFE0, address bits compared for the SID window

Ports:
iCPC_CLOCK  in  1  sole clock, rising-edge
iRESET_N  in  1  reset, asynchronous, active-low
iIORQ, iRD, iWR  in  1 each  CPC strobes, active-low, asynchronous to the clock
iADR  in  16  CPC address
iCPC_DATA  in  8  CPC data bus input
oCPC_DATA  out  8  CPC read data
oCPC_DATA_OE  out  1  high = drive CPC data bus
iATMEGA_DATA  in  8  ATmega reply byte
oATMEGA_DATA  out  8  FIFO head byte (show-ahead)
oFIFO_NONEMPTY  out  1  high while FIFO holds data; ATmega attention line
iATMEGA_POP  in  1  rising edge pops the FIFO head
iATMEGA_STORE  in  1  rising edge latches iATMEGA_DATA into the reply register
iATMEGA_READY  in  1  ATmega command-loop ready
iSID_ON  in  1  enables SID decode
oSID_CS, oSID_RW  out  1 each  SID strobes, active-low
oSID_CLOCK  out  1  divided SID clock

Behaviour:
- Reset (async assert): FIFO empty (pointers and count = 0), overflow = 0, reply = 8'h00, SID counter = 0, oSID_CLOCK = 1. All synchroniser flops reset to the idle level (strobes high, POP/STORE low). Reset mid-transaction discards any pending push or pop.
- iIORQ, iRD, iWR, iATMEGA_POP and iATMEGA_STORE pass through 2-flop synchronisers. wr_act = both IORQ and WR synced low; rd_act likewise with RD.
- Write event: single-cycle pulse on the rising edge of wr_act, i.e. 3 cycles after the strobes fall. iADR and iCPC_DATA are sampled raw in that cycle.
- Write event with iADR == SPEECH_ADR:
  - FIFO not full: push iCPC_DATA.
  - FIFO full: drop the byte and set the sticky overflow bit.
- Read path: oCPC_DATA_OE is combinational from the raw pins: IORQ & RD low and (iADR == SPEECH_ADR or iADR == STATUS_ADR). oCPC_DATA is a combinational mux of registered values:
  - SPEECH_ADR returns the reply register.
  - STATUS_ADR returns {iATMEGA_READY, overflow, empty, full, level[3:0]}; level saturates at 15.
- Overflow is cleared on the falling edge of rd_act (end of cycle) for a STATUS_ADR read. The value stays stable during the read. If a set and a clear fall in the same cycle, set wins.
- Pop: synced rising edge of iATMEGA_POP advances the read pointer. Pop when empty is ignored. oATMEGA_DATA shows the new head the cycle after a pop or after a push into an empty FIFO. oFIFO_NONEMPTY = count != 0, registered.
- Push and pop in the same cycle: both execute and count is unchanged. When full, that push is accepted and no overflow is set.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH+1).
- Store: synced rising edge of iATMEGA_STORE latches the raw iATMEGA_DATA into the reply register; 3-cycle latency.
- SID strobes, combinational from raw pins:
  - oSID_CS = ~(iSID_ON & (iADR & SID_MASK) == SID_BASE & IORQ low & (RD low | WR low)).
  - oSID_RW = ~(same decode & WR low).
  - Both are forced high while iRESET_N is low.
- SID clock: counter 0..SID_DIV/2-1; oSID_CLOCK toggles at the wrap.

Optional Feature:
Macro FIFO_FLUSH_EN.
- Defined: a write event to STATUS_ADR with iCPC_DATA[7] = 1 empties the FIFO and clears overflow in one cycle. A same-cycle ATmega pop is ignored.
- Undefined: writes to STATUS_ADR have no effect.

Test Plan:
- Reset, then 3 writes 0x11, 0x22, 0x33 to FBEE -> status read = 0x80|0x03 with READY = 1. oATMEGA_DATA = 0x11; after one pop it is 0x22.
- DEPTH = 8: 9 writes -> status bits full = 1 and overflow = 1, level = 8. 9th byte absent. Second status read shows overflow = 0.
- FIFO full, CPC write coincident with POP edge -> count stays 8, no overflow, new byte appears at tail.
- Pulse STORE with iATMEGA_DATA = 0xA5 -> CPC read of FBEE returns 0xA5 and OE is high only during IORQ & RD low.
- iSID_ON = 1, write FAC5 -> oSID_CS and oSID_RW low only during the strobe. iSID_ON = 0 -> both stay high. oSID_CLOCK period = 4 clocks, starts high.
- FIFO_FLUSH_EN: 5 bytes, write 0x80 to FBDE -> status level 0, oFIFO_NONEMPTY = 0. Assert iRESET_N mid-write -> no push after release.
